// File: rtl/prn_chip_spreader_pkg.sv
// Shared types and sizing helpers for the PRN chip spreader.
// Holds the FSM state encoding, the default code length and the counter-width helper.
package navicl1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int CODE_LEN_DEF = 1800;

    // Per-chip output event, registered as one bundle so every strobe shares an edge.
    typedef struct packed {
        logic chip_out;
        logic chip_valid;
        logic epoch_start;
        logic sym_start;
        logic underrun;
    } chip_evt_t;

    // $clog2 collapses to zero for a count of one; counters always need at least one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prn_chip_spreader_if.sv
// Handshake and chip-stream bundle between the code/symbol source, the spreader and the modulator.
interface prn_chip_spreader_if
    import navicl1_pkg::*;
#(
    parameter int CODE_LEN = CODE_LEN_DEF
);

    logic [0:CODE_LEN-1] code_in;
    logic                code_valid;
    logic                code_ready;
    logic                start;
    logic                stop;
    logic                sym_in;
    logic                sym_valid;
    logic                sym_ready;
    logic                chip_out;
    logic                chip_valid;
    logic                epoch_start;
    logic                sym_start;
    logic                busy;
    logic                underrun;

    modport master (
        output code_in, code_valid, start, stop, sym_in, sym_valid,
        input  code_ready, sym_ready, chip_out, chip_valid, epoch_start,
               sym_start, busy, underrun
    );

    modport slave (
        input  code_in, code_valid, start, stop, sym_in, sym_valid,
        output code_ready, sym_ready, chip_out, chip_valid, epoch_start,
               sym_start, busy, underrun
    );

endinterface

// File: rtl/prn_chip_spreader_sym_slot.sv
// One-entry navigation-symbol holding register: valid/ready fill side, consume pulse drain side.
module sym_slot (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sym,
    input  logic i_sym_valid,
    output logic o_sym_ready,
    input  logic i_consume,
    output logic o_full,
    output logic o_sym
);

    logic r_full;
    logic r_sym;
    logic w_load;

    assign o_sym_ready = !r_full;
    assign w_load      = i_sym_valid && !r_full;
    assign o_full      = r_full;
    assign o_sym       = r_sym;

    // Drain is applied before fill so a same-edge load always leaves the slot holding the new symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_sym  <= 1'b0;
        end else begin
            if (i_consume) begin
                r_full <= 1'b0;
            end
            if (w_load) begin
                r_full <= 1'b1;
                r_sym  <= i_sym;
            end
        end
    end

endmodule

// File: rtl/prn_chip_spreader.sv
// Latches one parallel PRN code block and replays it serially, one chip per strobe,
// XOR-spread with the current navigation data symbol.
module prn_chip_spreader
    import navicl1_pkg::*;
#(
    parameter int CODE_LEN       = CODE_LEN_DEF,
    parameter int CHIP_DIV       = 1,
    parameter int EPOCHS_PER_SYM = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    prn_chip_spreader_if.slave io
);

    localparam int IDX_W = cnt_w(CODE_LEN);
    localparam int DIV_W = cnt_w(CHIP_DIV);
    localparam int EP_W  = cnt_w(EPOCHS_PER_SYM);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHIP_DIV - 1);
    localparam logic [EP_W-1:0]  EP_LAST  = EP_W'(EPOCHS_PER_SYM - 1);

    state_t              r_state;
    logic [0:CODE_LEN-1] r_code;
    logic [IDX_W-1:0]    r_idx;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [EP_W-1:0]     r_epoch_cnt;
    logic                r_cur_sym;
    logic                r_stop_req;
    chip_evt_t           r_evt;

    logic w_tick;
    logic w_sym_bnd;
    logic w_slot_full;
    logic w_slot_sym;
    logic w_slot_ready;
    logic w_consume;
    logic w_sym_eff;
    logic w_last_chip;
    logic w_halt;

    sym_slot u_sym_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sym      (io.sym_in),
        .i_sym_valid(io.sym_valid),
        .o_sym_ready(w_slot_ready),
        .i_consume  (w_consume),
        .o_full     (w_slot_full),
        .o_sym      (w_slot_sym)
    );

    assign w_tick      = (r_state == RUN) && (r_div_cnt == DIV_LAST);
    assign w_sym_bnd   = w_tick && (r_idx == '0) && (r_epoch_cnt == '0);
    assign w_consume   = w_sym_bnd && w_slot_full;
    // A fresh symbol spreads the boundary chip itself; an empty slot spreads with zero.
    assign w_sym_eff   = w_sym_bnd ? (w_slot_full & w_slot_sym) : r_cur_sym;
    assign w_last_chip = w_tick && (r_idx == IDX_LAST);
    assign w_halt      = w_last_chip && (r_stop_req || io.stop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_idx       <= '0;
            r_div_cnt   <= '0;
            r_epoch_cnt <= '0;
            r_cur_sym   <= 1'b0;
            r_stop_req  <= 1'b0;
            r_evt       <= '0;
        end else begin
            r_evt.chip_valid  <= w_tick;
            r_evt.epoch_start <= w_tick && (r_idx == '0);
            r_evt.sym_start   <= w_sym_bnd;
            r_evt.underrun    <= w_sym_bnd && !w_slot_full;
            if (w_tick) begin
                r_evt.chip_out <= r_code[r_idx] ^ w_sym_eff;
            end
            if (w_sym_bnd) begin
                r_cur_sym <= w_slot_full & w_slot_sym;
            end

            case (r_state)
                IDLE: begin
                    if (io.code_valid) begin
                        r_code  <= io.code_in;
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (io.stop) begin
                        r_state <= IDLE;
                    end else if (io.start) begin
                        r_state     <= RUN;
                        r_idx       <= '0;
                        r_div_cnt   <= '0;
                        r_epoch_cnt <= '0;
                        r_stop_req  <= 1'b0;
                    end
                end
                RUN: begin
                    if (io.stop) begin
                        r_stop_req <= 1'b1;
                    end
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_idx       <= '0;
                            r_epoch_cnt <= (r_epoch_cnt == EP_LAST) ? '0 : r_epoch_cnt + 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                    // Halting only after the last chip keeps every emitted epoch whole.
                    if (w_halt) begin
                        r_state    <= IDLE;
                        r_stop_req <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io.code_ready  = (r_state == IDLE);
    assign io.busy        = (r_state == RUN);
    assign io.sym_ready   = w_slot_ready;
    assign io.chip_out    = r_evt.chip_out;
    assign io.chip_valid  = r_evt.chip_valid;
    assign io.epoch_start = r_evt.epoch_start;
    assign io.sym_start   = r_evt.sym_start;
    assign io.underrun    = r_evt.underrun;

endmodule

// File: doc/prn_chip_spreader.md
Name: prn_chip_spreader

Overview:
Downstream consumer of the PRNO L1 code generator. Latches one full parallel PRN code block (P), then replays it serially one chip per chip strobe, epoch after epoch. Each chip is XOR-spread with the current navigation data symbol. Outputs feed the baseband modulator.

Parameters:
CODE_LEN, 1800, chips per code epoch; width of code_in.
CHIP_DIV, 1, clk cycles per chip (1..255); 1 means one chip per clk.
EPOCHS_PER_SYM, 2, code epochs spread by one data symbol (1..255).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
code_in  in  [0:CODE_LEN-1]  parallel PRN chips from PRNO.P; bit 0 is the first chip transmitted
code_valid  in  1  code_in valid
code_ready  out  1  spreader can accept a code (IDLE only)
start  in  1  begin spreading (honoured in ARMED only)
stop  in  1  request halt at the next epoch boundary
sym_in  in  1  navigation data symbol
sym_valid  in  1  sym_in valid
sym_ready  out  1  symbol slot empty
chip_out  out  1  code_reg[idx] ^ cur_sym, registered
chip_valid  out  1  one-clk strobe per chip
epoch_start  out  1  high with chip_valid when idx==0
sym_start  out  1  high with chip_valid when idx==0 and epoch_cnt==0
busy  out  1  state==RUN
underrun  out  1  one-clk pulse: symbol boundary reached with the slot empty

Behaviour:
- Reset (async, rst_n=0): state=IDLE, code_reg=0, idx=0, div_cnt=0, epoch_cnt=0, cur_sym=0, slot empty. All outputs 0 except code_ready=1 and sym_ready=1. Reset mid-RUN aborts immediately with no further chip_valid.
- Clock and reset ports are named clk and rst_n. Reset is asynchronous and active-low. All state is on the rising edge of clk.
- States:
  - IDLE: code_ready=1. code_valid=1 latches code_in into code_reg, then go to ARMED.
  - ARMED: code_ready=0. start=1 goes to RUN with idx=0, div_cnt=0, epoch_cnt=0, and a stop request cleared.
  - RUN:
    - Chip tick occurs when div_cnt==CHIP_DIV-1. div_cnt wraps to 0 after each tick.
    - On a tick: chip_out<=code_reg[idx]^sym_eff, chip_valid<=1, then idx advances.
    - idx wraps from CODE_LEN-1 to 0, and the wrap increments epoch_cnt modulo EPOCHS_PER_SYM.
- Latency: start sampled at edge k gives the first chip_valid (idx 0) after edge k+CHIP_DIV. Chips are spaced exactly CHIP_DIV clks apart, with no gap at epoch wrap.
- Symbol boundary (tick with idx==0 and epoch_cnt==0, including the first RUN chip):
  - Slot full: cur_sym<=slot, slot empties, and sym_eff is the new symbol for this same chip.
  - Slot empty: cur_sym<=0, sym_eff=0, underrun pulses, and spreading continues.
- Symbol slot:
  - sym_ready = slot empty.
  - sym_valid && sym_ready fills the slot in any state.
  - Load and consume on the same edge: consume first; the new symbol then fills the slot.
- stop:
  - In RUN, stop sets a sticky request. After the tick with idx==CODE_LEN-1, go to IDLE.
  - The last chip is still emitted, and code_reg is kept.
  - stop in ARMED returns to IDLE. stop in IDLE is ignored.
  - start and stop together in ARMED: stop wins.
- code_valid outside IDLE is ignored; a code is never replaced mid-epoch.
- chip_valid, epoch_start, sym_start and underrun are 0 on all non-tick cycles.

Decomposition:
- Package navicl1_pkg:
  - state enum {IDLE, ARMED, RUN};
  - default CODE_LEN=1800;
  - counter widths via $clog2(CODE_LEN), $clog2(CHIP_DIV), $clog2(EPOCHS_PER_SYM).
- Sub-module sym_slot: one-entry valid/ready symbol holding register with a consume port, instantiated once.

Test Plan:
- Basic spreading: CODE_LEN=8, CHIP_DIV=1, EPOCHS_PER_SYM=1; code 10110010 loaded, symbol 1 queued, start. Required: chips 0,1,0,0,1,1,0,1; first chip_valid one clk after start; epoch_start on chip 0; no underrun.
- Symbol boundary: EPOCHS_PER_SYM=2, symbols 0 then 1 queued. Required: 16 chips equal the code; the next 16 are the inverted code; sym_start on chips 0 and 16 only.
- Underrun: slot left empty at the second symbol boundary. Required: underrun is a single pulse with sym_start; chips equal the raw code; no gap.
- Chip divider: CHIP_DIV=3. Required: chip_valid every 3rd clk; first chip 3 clks after start; epoch_start spacing 24 clks.
- Stop and reset: stop asserted at idx=3. Required: chips through idx=7, then busy=0, code_ready=1. rst_n=0 pulsed mid-RUN: outputs go to 0 immediately; code_ready=1 and sym_ready=1.
- PRNO handoff: CODE_LEN=1800, code_in driven from PRNO with the first R0/R1 pair. Required: chips 0..23 match PRNO.first; chips 1776..1799 match PRNO.last; code_valid ignored while in RUN.
